// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arb_pkg: shared types and helpers for the round-robin bus interconnect
// Provides the FSM state type, slave-select width and the address-to-slave decode.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  localparam int SEL_W = 4;
  // slave index lives in the top SEL_W bits of an aw-bit address
  function automatic logic [SEL_W-1:0] sel_of(input logic [63:0] addr, input int aw);
    return SEL_W'(addr >> (aw - SEL_W));
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: master-side and slave-side signals of the shared bus
// Ports (signals): m_valid/m_read/m_write/m_addr/m_wdata from masters, m_ready/m_rdata/m_err back;
// s_valid/s_read/s_write/s_addr/s_wdata to slaves, s_ready/s_rdata back.
// Modports: master (bus masters), slave (bus slaves), arb (the interconnect).
interface bus_arbiter_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]        m_valid, m_read, m_write, m_ready;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0]           m_rdata;
  logic                        m_err;
  logic [N_SLAVES-1:0]         s_valid, s_ready;
  logic                        s_read, s_write;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  logic [N_SLAVES*DATA_W-1:0]  s_rdata;
  modport master (output m_valid, m_read, m_write, m_addr, m_wdata,
                  input  m_ready, m_rdata, m_err);
  modport slave  (input  s_valid, s_read, s_write, s_addr, s_wdata,
                  output s_ready, s_rdata);
  modport arb    (input  m_valid, m_read, m_write, m_addr, m_wdata, s_ready, s_rdata,
                  output m_ready, m_rdata, m_err, s_valid, s_read, s_write, s_addr, s_wdata);
endinterface

// File: rtl/bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr
// Ports: req (request vector), ptr (last granted index), gnt (one-hot), idx (grant index), any (some request).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  // rot[k] is the request of master (ptr+1+k) mod N; scanning downwards leaves the nearest one
  always_comb begin
    rot = N'({req, req} >> (int'(ptr) + 1));
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx = IW'((int'(ptr) + 1 + k) % N);
  end
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin N-master / M-slave shared bus, one transfer in flight
// Ports: clk, rst_n (async active-low), bus (bus_arbiter_rr_if.arb: master and slave sides).
// Slave i owns addresses whose top nibble equals i. Undecodable address or read==write
// answers with m_err without touching a slave.
// Optional BUS_TIMEOUT_EN: abort an ADDR phase after TIMEOUT_CYC cycles without s_ready.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS   = 4,
  parameter int N_SLAVES    = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input logic            clk,
  input logic            rst_n,
  bus_arbiter_rr_if.arb  bus
);
  localparam int IW = $clog2(N_MASTERS);
  if (N_MASTERS < 2 || N_MASTERS > 8 || N_SLAVES < 1 || N_SLAVES > 16 || ADDR_W < 5 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("bus_arbiter_rr: parameter out of range");
  end
  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, grant_q, grant_d, arb_idx;
  logic [N_MASTERS-1:0] arb_gnt;
  logic                 arb_any;
  logic [ADDR_W-1:0]    addr_q, addr_d, req_addr;
  logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, req_wdata, sl_rdata;
  logic                 rd_q, rd_d, wr_q, wr_d, err_q, err_d, req_rd, req_wr, hit, expired;
  logic [SEL_W-1:0]     sel_q, sel_d, req_sel;
  logic [N_SLAVES-1:0]  sel_hot;
  rr_arbiter #(.N(N_MASTERS)) u_arb (
    .req (bus.m_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );
  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    sl_rdata  = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (arb_gnt[i]) begin
        req_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
        req_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
        req_rd    = bus.m_read[i];
        req_wr    = bus.m_write[i];
      end
    for (int i = 0; i < N_SLAVES; i++)
      if (sel_q == SEL_W'(i)) sl_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
  end
  assign req_sel = sel_of(64'(req_addr), ADDR_W);
  assign sel_hot = N_SLAVES'(1) << sel_q;
  assign hit     = |(bus.s_ready & sel_hot);
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  // restarts from zero every time ADDR is entered because it is held clear elsewhere
  always_comb tmr_d = state_q == ADDR ? tmr_q + 1'b1 : '0;
  assign expired = tmr_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (arb_any) begin
        grant_d = arb_idx;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rd_d    = req_rd;
        wr_d    = req_wr;
        sel_d   = req_sel;
        rdata_d = '0;
        err_d   = (32'(req_sel) >= N_SLAVES) || (req_rd == req_wr);
        state_d = err_d ? RESP : ADDR;
      end
      // a ready arriving on the expiry cycle still completes normally
      ADDR: if (hit || expired) begin
        rdata_d = hit && rd_q ? sl_rdata : '0;
        err_d   = !hit;
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_MASTERS - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign bus.s_valid = state_q == ADDR ? sel_hot : '0;
  assign bus.s_read  = state_q == ADDR && rd_q;
  assign bus.s_write = state_q == ADDR && wr_q;
  assign bus.s_addr  = state_q == ADDR ? addr_q : '0;
  assign bus.s_wdata = state_q == ADDR ? wdata_q : '0;
  assign bus.m_ready = state_q == RESP ? N_MASTERS'(1) << grant_q : '0;
  assign bus.m_rdata = state_q == RESP ? rdata_q : '0;
  assign bus.m_err   = state_q == RESP && err_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed bench with a transaction-level reference model
module tb_bus_arbiter_rr;
  localparam int NM = 4, NS = 4, AW = 16, DW = 32, TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bus_arbiter_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();
  bus_arbiter_rr #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int n_chk = 0, n_fail = 0, cyc = 0;
  int pend[NM], st_cyc[NM];
  logic m_rd_c[NM], m_wr_c[NM];
  logic [AW-1:0] m_ad_c[NM];
  logic [DW-1:0] m_wd_c[NM];
  int lat[NS], wcnt[NS];
  logic noise[NS];
  logic [DW-1:0] sdat[NS];
  int ph, mptr, mg, msel, tcnt;
  logic merr, mr, mw;
  logic [AW-1:0] ma;
  logic [DW-1:0] mrd, mwd;
  int log_g[$], log_c[$];
  logic [DW-1:0] log_d[$];
  logic log_e[$];
  int sv_cnt, base;
  logic [NS-1:0] last_sv;
  logic [AW-1:0] last_sa;
  logic [DW-1:0] last_swd;
  logic last_sw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_masters();
    for (int i = 0; i < NM; i++) begin
      bus.m_valid[i] = pend[i] > 0;
      bus.m_read[i]  = m_rd_c[i];
      bus.m_write[i] = m_wr_c[i];
      bus.m_addr[i*AW +: AW]  = m_ad_c[i];
      bus.m_wdata[i*DW +: DW] = m_wd_c[i];
    end
  endtask

  // one bus cycle of the reference: arbitrate, talk to the slave, answer the master
  task automatic model_step();
    if (!rst_n) begin
      ph = 0; mptr = NM - 1; mg = 0; merr = 1'b0; mrd = '0;
      return;
    end
    case (ph)
      0: if (bus.m_valid != 0) begin
        for (int k = NM; k >= 1; k--) if (bus.m_valid[(mptr + k) % NM]) mg = (mptr + k) % NM;
        ma = m_ad_c[mg]; mwd = m_wd_c[mg]; mr = m_rd_c[mg]; mw = m_wr_c[mg];
        msel = int'(ma[AW-1 -: 4]);
        if (msel >= NS || mr == mw) begin ph = 2; merr = 1'b1; mrd = '0; end
        else begin ph = 1; tcnt = 0; end
      end
      1: if (bus.s_ready[msel]) begin
        mrd = mr ? sdat[msel] : '0; merr = 1'b0; ph = 2;
      end else begin
        tcnt++;
`ifdef BUS_TIMEOUT_EN
        if (tcnt == TO) begin merr = 1'b1; mrd = '0; ph = 2; end
`endif
      end
      default: begin mptr = mg; ph = 0; end
    endcase
  endtask

  task automatic compare();
    logic [NS-1:0] esv;
    logic [NM-1:0] emr;
    esv = ph == 1 ? NS'(1) << msel : '0;
    emr = ph == 2 ? NM'(1) << mg : '0;
    chk("s_valid", bus.s_valid, esv);
    chk("m_ready", bus.m_ready, emr);
    chk("m_rdata", bus.m_rdata, ph == 2 ? mrd : '0);
    chk("m_err", bus.m_err, ph == 2 && merr);
    if (ph == 1) begin
      chk("s_read", bus.s_read, mr);
      chk("s_write", bus.s_write, mw);
      chk("s_addr", bus.s_addr, ma);
      chk("s_wdata", bus.s_wdata, mwd);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    compare();
    for (int i = 0; i < NM; i++)
      if (bus.m_ready[i]) begin
        log_g.push_back(i); log_c.push_back(cyc); log_d.push_back(bus.m_rdata); log_e.push_back(bus.m_err);
        if (pend[i] > 0) pend[i]--;
      end
    if (bus.s_valid != 0) begin
      sv_cnt++; last_sv = bus.s_valid; last_sa = bus.s_addr; last_swd = bus.s_wdata; last_sw = bus.s_write;
    end
    for (int s = 0; s < NS; s++)
      if (bus.s_valid[s]) begin
        bus.s_ready[s] = lat[s] >= 0 && wcnt[s] >= lat[s];
        wcnt[s]++;
      end else begin
        bus.s_ready[s] = noise[s];
        wcnt[s] = 0;
      end
    drive_masters();
  endtask

  task automatic req(input int i, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
    m_rd_c[i] = rd; m_wr_c[i] = wr; m_ad_c[i] = a; m_wd_c[i] = d; pend[i] = n; st_cyc[i] = cyc;
    drive_masters();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int b = 0;
    while (log_g.size() < n && b < budget) begin tick(); b++; end
    chk({name, " completion"}, log_g.size() >= n, 1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < NM; i++) pend[i] = 0;
    drive_masters();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      pend[i] = 0; m_rd_c[i] = 1'b0; m_wr_c[i] = 1'b0; m_ad_c[i] = '0; m_wd_c[i] = '0; st_cyc[i] = 0;
    end
    sdat[0] = 32'hDEADBEEF; sdat[1] = 32'h1111_0001; sdat[2] = 32'h2222_0002; sdat[3] = 32'h3333_0003;
    for (int s = 0; s < NS; s++) begin
      lat[s] = 0; wcnt[s] = 0; noise[s] = 1'b0; bus.s_rdata[s*DW +: DW] = sdat[s];
    end
    bus.s_ready = '0;
    ph = 0; mptr = NM - 1; mg = 0; msel = 0; tcnt = 0; merr = 1'b0; mr = 1'b0; mw = 1'b0;
    ma = '0; mrd = '0; mwd = '0; sv_cnt = 0;
    drive_masters();
    do_reset();
    chk("reset s_valid", bus.s_valid, 0);
    chk("reset m_ready", bus.m_ready, 0);
    chk("reset m_rdata", bus.m_rdata, 0);
    chk("reset m_err", bus.m_err, 0);
    // single read from master 0
    req(0, 1'b1, 1'b0, 16'h0004, '0, 1);
    wait_log(1, 20, "t1");
    chk("t1 grant", log_g[0], 0);
    chk("t1 latency", log_c[0] - st_cyc[0] + 1, 3);
    chk("t1 rdata", log_d[0], 32'hDEADBEEF);
    chk("t1 err", log_e[0], 0);
    tick(); tick();
    // all masters request continuously
    do_reset();
    for (int s = 0; s < NS; s++) lat[s] = 1;
    base = log_g.size();
    for (int i = 0; i < NM; i++) req(i, 1'b1, 1'b0, AW'(i << 12) | AW'(i * 4), '0, 2);
    wait_log(base + 8, 100, "t2");
    chk("t2 grant0", log_g[base], 0);
    chk("t2 grant1", log_g[base+1], 1);
    chk("t2 grant2", log_g[base+2], 2);
    chk("t2 grant3", log_g[base+3], 3);
    chk("t2 grant4", log_g[base+4], 0);
    chk("t2 grant5", log_g[base+5], 1);
    chk("t2 rdata0", log_d[base], 32'hDEADBEEF);
    chk("t2 rdata1", log_d[base+1], 32'h1111_0001);
    tick(); tick();
    // write to slave 2 while slave 0 asserts a stray ready
    noise[0] = 1'b1; lat[2] = 2; sv_cnt = 0; base = log_g.size();
    req(2, 1'b0, 1'b1, 16'h2010, 32'hA5A5_0102, 1);
    wait_log(base + 1, 20, "t3");
    chk("t3 s_valid", last_sv, 4'b0100);
    chk("t3 s_addr", last_sa, 16'h2010);
    chk("t3 s_wdata", last_swd, 32'hA5A5_0102);
    chk("t3 s_write", last_sw, 1);
    chk("t3 addr cycles", sv_cnt, 3);
    chk("t3 err", log_e[base], 0);
    chk("t3 rdata", log_d[base], 0);
    noise[0] = 1'b0;
    tick(); tick();
    // decode error and malformed strobes
    sv_cnt = 0; base = log_g.size();
    req(1, 1'b1, 1'b0, 16'hF000, '0, 1);
    wait_log(base + 1, 20, "t4a");
    chk("t4a err", log_e[base], 1);
    chk("t4a rdata", log_d[base], 0);
    chk("t4a latency", log_c[base] - st_cyc[1] + 1, 2);
    tick(); tick();
    req(3, 1'b1, 1'b1, 16'h1000, 32'h1, 1);
    wait_log(base + 2, 20, "t4b");
    chk("t4b err", log_e[base+1], 1);
    tick(); tick();
    req(3, 1'b0, 1'b0, 16'h1000, 32'h1, 1);
    wait_log(base + 3, 20, "t4c");
    chk("t4c err", log_e[base+2], 1);
    chk("t4 no slave access", sv_cnt, 0);
    tick(); tick();
    // reset in the middle of an ADDR phase
    lat[1] = -1;
    req(0, 1'b1, 1'b0, 16'h1000, '0, 1);
    tick();
    chk("t5 pre s_valid", bus.s_valid, 4'b0010);
    base = log_g.size();
    #2 rst_n = 1'b0;
    #1;
    chk("t5 s_valid drop", bus.s_valid, 0);
    chk("t5 m_ready", bus.m_ready, 0);
    for (int i = 0; i < NM; i++) pend[i] = 0;
    drive_masters();
    tick(); tick();
    rst_n = 1'b1;
    chk("t5 no response", log_g.size(), base);
    lat[1] = 0;
    req(2, 1'b1, 1'b0, 16'h0008, '0, 1);
    req(0, 1'b1, 1'b0, 16'h0000, '0, 1);
    wait_log(base + 2, 30, "t5");
    chk("t5 first", log_g[base], 0);
    chk("t5 second", log_g[base+1], 2);
    tick(); tick();
    // slave that never answers
    lat[1] = -1; sv_cnt = 0; base = log_g.size();
    req(0, 1'b1, 1'b0, 16'h1000, '0, 1);
`ifdef BUS_TIMEOUT_EN
    wait_log(base + 1, 40, "t6");
    chk("t6 err", log_e[base], 1);
    chk("t6 rdata", log_d[base], 0);
    chk("t6 addr cycles", sv_cnt, TO);
    chk("t6 latency", log_c[base] - st_cyc[0] + 1, TO + 2);
`else
    repeat (100) tick();
    chk("t6 addr cycles", sv_cnt, 100);
    chk("t6 no response", log_g.size(), base);
    chk("t6 s_valid held", bus.s_valid, 4'b0010);
    do_reset();
`endif
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
